// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the IF/ID, ID/EX and EX/MEM pipeline registers:
// load-use stalls, mult/div occupancy tracking with HI/LO interlock, and taken-branch flushes.
//
//   state | meaning
//   IDLE  | HI/LO unit free; a mult/div in ID may launch
//   BUSY  | mult/div in flight; count holds the remaining cycles
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 3
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       ID_IsMultDiv,
    input  logic       ID_IsMfHiLo,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_WriteAddr,
    input  logic       BranchTaken,
    output logic       PCWriteEn,
    output logic       IFID_WriteEn,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       EXMEM_Flush,
    output logic       MD_Start,
    output logic       MD_Abort,
    output logic       MD_Busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             md_in_ex;
    logic             load_use;
    logic             md_hazard;
    logic             stall;

    assign load_use  = EX_MemRead && (EX_WriteAddr != 5'd0) &&
                       ((EX_WriteAddr == ID_Rs) || (ID_UsesRt && (EX_WriteAddr == ID_Rt)));
    assign md_hazard = MD_Busy && (ID_IsMultDiv || ID_IsMfHiLo);
    assign stall     = (load_use || md_hazard) && !BranchTaken;

    assign MD_Start = Rst_n && ID_IsMultDiv && !MD_Busy && !load_use && !BranchTaken;
    // Only a mult/div younger than the branch (just issued, now in EX) is killed.
    assign MD_Abort = Rst_n && BranchTaken && md_in_ex;

    always_comb begin
        PCWriteEn    = 1'b1;
        IFID_WriteEn = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Flush  = 1'b0;
        if (!Rst_n) begin
            PCWriteEn    = 1'b0;
            IFID_WriteEn = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            EXMEM_Flush  = 1'b1;
        end else if (BranchTaken) begin
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            EXMEM_Flush  = 1'b1;
        end else if (stall) begin
            PCWriteEn    = 1'b0;
            IFID_WriteEn = 1'b0;
            IDEX_Flush   = 1'b1;
        end
    end

    // Updates on the falling edge so it lines up with the pipeline registers it controls.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            count    <= '0;
            md_in_ex <= 1'b0;
            MD_Busy  <= 1'b0;
        end else if (MD_Abort) begin
            state    <= IDLE;
            count    <= '0;
            md_in_ex <= 1'b0;
            MD_Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MD_Start) begin
                        state    <= BUSY;
                        count    <= CNT_W'(MD_LATENCY);
                        md_in_ex <= 1'b1;
                        MD_Busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    count    <= count - 1'b1;
                    md_in_ex <= 1'b0;
                    if (count == CNT_W'(1)) begin
                        state   <= IDLE;
                        MD_Busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    md_in_ex <= 1'b0;
                    MD_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: hand-derived expected output vectors are
// queued as each cycle's stimulus is applied and compared once the outputs have settled.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       br;
        logic       memrd;
        logic [4:0] waddr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       is_md;
        logic       is_mf;
    } stim_t;

    // Output vector: {PCWriteEn, IFID_WriteEn, IFID_Flush, IDEX_Flush, EXMEM_Flush, MD_Start, MD_Abort, MD_Busy}
    localparam logic [7:0] O_RUN   = 8'b1100_0000;
    localparam logic [7:0] O_STALL = 8'b0001_0000;
    localparam logic [7:0] O_BR    = 8'b1111_1000;
    localparam logic [7:0] O_RST   = 8'b0011_1000;
    localparam logic [7:0] B_START = 8'b0000_0100;
    localparam logic [7:0] B_ABORT = 8'b0000_0010;
    localparam logic [7:0] B_BUSY  = 8'b0000_0001;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [4:0] ID_Rs = '0;
    logic [4:0] ID_Rt = '0;
    logic       ID_UsesRt = 1'b0;
    logic       ID_IsMultDiv = 1'b0;
    logic       ID_IsMfHiLo = 1'b0;
    logic       EX_MemRead = 1'b0;
    logic [4:0] EX_WriteAddr = '0;
    logic       BranchTaken = 1'b0;
    logic       PCWriteEn, IFID_WriteEn, IFID_Flush, IDEX_Flush, EXMEM_Flush;
    logic       MD_Start, MD_Abort, MD_Busy;
    logic [7:0] outv;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsMultDiv(ID_IsMultDiv), .ID_IsMfHiLo(ID_IsMfHiLo),
        .EX_MemRead(EX_MemRead), .EX_WriteAddr(EX_WriteAddr), .BranchTaken(BranchTaken),
        .PCWriteEn(PCWriteEn), .IFID_WriteEn(IFID_WriteEn), .IFID_Flush(IFID_Flush),
        .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
        .MD_Start(MD_Start), .MD_Abort(MD_Abort), .MD_Busy(MD_Busy)
    );

    assign outv = {PCWriteEn, IFID_WriteEn, IFID_Flush, IDEX_Flush, EXMEM_Flush,
                   MD_Start, MD_Abort, MD_Busy};

    always #5 Clk = ~Clk;

    function automatic stim_t mk(logic br, logic memrd, logic [4:0] waddr, logic [4:0] rs,
                                 logic [4:0] rt, logic uses_rt, logic is_md, logic is_mf);
        stim_t s;
        s = '{br, memrd, waddr, rs, rt, uses_rt, is_md, is_mf};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        BranchTaken  = s.br;
        EX_MemRead   = s.memrd;
        EX_WriteAddr = s.waddr;
        ID_Rs        = s.rs;
        ID_Rt        = s.rt;
        ID_UsesRt    = s.uses_rt;
        ID_IsMultDiv = s.is_md;
        ID_IsMfHiLo  = s.is_mf;
    endtask

    // Inputs change in the high phase; the state-updating falling edge lies between cycles.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] want;
        next_cycle();
        apply(mk(0, 1, 5'd4, 5'd4, 0, 0, 1, 0));
        exp_q.push_back(O_RST);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (outv !== want) begin
            errors++;
            $display("FAIL reset_hold got=%b want=%b", outv, want);
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        Rst_n = 1'b1;
        exp_q.push_back(O_RUN);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (outv !== want) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", outv, want);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        stim_t st[6];
        logic [7:0] ex[6];
        logic [7:0] want;
        st = '{mk(0, 1, 5'd8, 5'd8, 5'd1, 1, 0, 0),
               mk(0, 0, 5'd8, 5'd8, 5'd1, 1, 0, 0),
               mk(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0),
               mk(0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0),
               mk(0, 1, 5'd9, 5'd2, 5'd9, 0, 0, 0),
               mk(0, 1, 5'd31, 5'd31, 5'd3, 0, 0, 0)};
        ex = '{O_STALL, O_RUN, O_RUN, O_STALL, O_RUN, O_STALL};
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL load_use cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_mult_latency();
        stim_t st[7];
        logic [7:0] ex[7];
        logic [7:0] want;
        st = '{mk(0, 0, 0, 5'd4, 5'd5, 1, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 0)};
        ex = '{O_RUN | B_START,
               O_STALL | B_BUSY, O_STALL | B_BUSY, O_STALL | B_BUSY, O_STALL | B_BUSY,
               O_RUN, O_RUN};
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL mult_latency cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_abort();
        stim_t st[3];
        logic [7:0] ex[3];
        logic [7:0] want;
        st = '{mk(0, 0, 0, 0, 0, 0, 1, 0),
               mk(1, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 1)};
        ex = '{O_RUN | B_START, O_BR | B_ABORT | B_BUSY, O_RUN};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL abort cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_no_abort();
        stim_t st[6];
        logic [7:0] ex[6];
        logic [7:0] want;
        st = '{mk(0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(1, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0)};
        ex = '{O_RUN | B_START, O_RUN | B_BUSY, O_BR | B_BUSY,
               O_RUN | B_BUSY, O_RUN | B_BUSY, O_RUN};
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL no_abort cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_priority();
        stim_t st[2];
        logic [7:0] ex[2];
        logic [7:0] want;
        st = '{mk(1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0)};
        ex = '{O_BR, O_RUN};
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL branch_priority cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
    endtask

    // Overlapping load-use and HI/LO hazards, then a mult held off until the unit frees up.
    task automatic test_back_to_back();
        stim_t st[11];
        logic [7:0] ex[11];
        logic [7:0] want;
        st = '{mk(0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 1, 5'd3, 5'd3, 0, 0, 1, 0),
               mk(0, 0, 0, 5'd3, 0, 0, 1, 0),
               mk(0, 0, 0, 5'd3, 0, 0, 1, 0),
               mk(0, 0, 0, 5'd3, 0, 0, 1, 0),
               mk(0, 0, 0, 5'd3, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0)};
        ex = '{O_RUN | B_START,
               O_STALL | B_BUSY, O_STALL | B_BUSY, O_STALL | B_BUSY, O_STALL | B_BUSY,
               O_RUN | B_START,
               O_RUN | B_BUSY, O_RUN | B_BUSY, O_RUN | B_BUSY, O_RUN | B_BUSY,
               O_RUN};
        for (int i = 0; i < 11; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        stim_t st[3];
        logic [7:0] ex[3];
        logic [7:0] want;
        st = '{mk(0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0)};
        ex = '{O_RUN | B_START, O_RUN | B_BUSY, O_RUN | B_BUSY};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL async_pre cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
        // Count is now 2: reset lands in the high phase, well away from any falling edge.
        Rst_n = 1'b0;
        exp_q.push_back(O_RST);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (outv !== want) begin
            errors++;
            $display("FAIL async_assert got=%b want=%b", outv, want);
        end
        next_cycle();
        Rst_n = 1'b1;
        st = '{mk(0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0)};
        ex = '{O_RUN | B_START, O_RUN | B_BUSY, O_RUN | B_BUSY};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (outv !== want) begin
                errors++;
                $display("FAIL async_post cyc%0d got=%b want=%b", i, outv, want);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mult_latency();
        test_abort();
        test_no_abort();
        test_branch_priority();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
